wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage, directly downstream of the memory stage.
- Contains the MEM/WB pipeline register and the 32-entry architectural register file, with two combinational read ports for decode (internal WB-to-read bypass).
- Exposes WB-stage destination, data and write-enable for the execute-stage forwarding network.
- Contains a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, register and result width.
- REG_ADDR_WIDTH, 5, register index width; register count = 2**REG_ADDR_WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_stall  in  1  global pipeline freeze; WB register holds, no commit.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_drnum  in  REG_ADDR_WIDTH  destination register from MEM.
- mem_reg_we  in  1  instruction writes a register.
- mem_reg_data  in  DATA_WIDTH  load-extended or ALU result from MEM.
- rs1num  in  REG_ADDR_WIDTH  decode read index A.
- rs2num  in  REG_ADDR_WIDTH  decode read index B.
- rs1_data  out  DATA_WIDTH  read data A, combinational.
- rs2_data  out  DATA_WIDTH  read data B, combinational.
- wb_valid  out  1  WB holds a valid instruction (registered).
- wb_drnum  out  REG_ADDR_WIDTH  WB destination (registered).
- wb_reg_we  out  1  WB effective write enable for forwarding: registered mem_reg_we AND wb_valid AND wb_drnum != 0.
- wb_reg_data  out  DATA_WIDTH  WB write data (registered).
- wb_commit  out  1  combinational; high in cycles where the WB instruction retires.
- wb_instret  out  32  retired-instruction count.

Behaviour:
- Reset (async, rst=1):
  - wb_valid=0, wb_drnum=0, wb_reg_we=0, wb_reg_data=0, wb_instret=0.
  - All register-file entries cleared to 0.
  - Takes effect immediately, mid-cycle included.
  - Any in-flight WB instruction is discarded; it neither writes nor counts.
- Pipeline register, on rising clk when rst=0:
  - wb_stall=0: capture mem_valid, mem_drnum, mem_reg_we, mem_reg_data. Latency MEM to WB is 1 cycle.
  - wb_stall=1: hold all WB registers unchanged.
  - When mem_valid=0, capture it as a bubble. drnum and data may be captured as-is but have no effect.
- Commit:
  - commit = wb_valid AND NOT wb_stall.
  - On the rising edge ending a commit cycle:
    - Write the register file if wb_reg_we, i.e. regs[wb_drnum] <= wb_reg_data.
    - wb_instret <= wb_instret + 1, regardless of wb_reg_we (stores and branches count).
  - A stalled WB instruction commits exactly once, in the first unstalled cycle.
  - wb_instret wraps 0xFFFFFFFF -> 0x00000000 with no flag.
- Register 0:
  - Hardwired zero. Writes to index 0 are dropped.
  - rs1_data/rs2_data return 0 for index 0, including when WB targets 0.
- Read ports (combinational):
  - rsX_data = 0 if rsXnum == 0.
  - Else wb_reg_data if wb_reg_we AND wb_drnum == rsXnum (bypass; applies even when stalled).
  - Else regs[rsXnum].
  - Both ports may name the same register; both return identical data.
- Forwarding outputs:
  - Reflect WB register contents directly, and remain valid during stall.
  - wb_reg_we is forced low for bubbles and for drnum 0, so consumers need no extra qualification.
- No internal state machine beyond the pipeline register, register file and counter. No backpressure toward MEM beyond the shared wb_stall.

Test Plan:
- Reset then read all 32 indices -> every rs1_data/rs2_data = 0x00000000, wb_instret = 0, wb_reg_we = 0.
- MEM presents valid, drnum=5, we=1, data=0xDEADBEEF; next cycle rs1num=5 -> rs1_data = 0xDEADBEEF via bypass in the WB cycle. After the following edge it is still 0xDEADBEEF from the register file, and wb_instret = 1.
- MEM presents valid, drnum=0, we=1, data=0x12345678 -> wb_reg_we=0, rs1num=0 reads 0, wb_instret increments by 1.
- WB holds valid x7 <= 0x55; assert wb_stall for 3 cycles -> wb_commit=0 and wb_instret unchanged during the stall, bypass returns 0x55 throughout. On release, exactly one commit and wb_instret +1.
- Stream of 4 valid instructions interleaved with 2 bubbles (mem_valid=0, drnum=3, we=1) -> x3 is not written by the bubbles, and wb_instret ends at 4.
- Preload wb_instret to 0xFFFFFFFF via 2^32-1 commits (or force), then commit once -> wb_instret = 0. Assert rst mid-commit-cycle -> the register is not written and all outputs read 0 immediately.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, architectural register file with
// bypassed combinational read ports, forwarding taps and retired-instruction counter.
module wb_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_stall,
  input  logic                      mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_drnum,
  input  logic                      mem_reg_we,
  input  logic [DATA_WIDTH-1:0]     mem_reg_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs1num,
  input  logic [REG_ADDR_WIDTH-1:0] rs2num,
  output logic [DATA_WIDTH-1:0]     rs1_data,
  output logic [DATA_WIDTH-1:0]     rs2_data,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_drnum,
  output logic                      wb_reg_we,
  output logic [DATA_WIDTH-1:0]     wb_reg_data,
  output logic                      wb_commit,
  output logic [31:0]               wb_instret
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  mem_we_eff;

  // Qualify the write enable at capture so WB consumers see it ready to use.
  assign mem_we_eff = mem_reg_we && mem_valid && (mem_drnum != '0);

  assign wb_commit = wb_valid && !wb_stall;

  // MEM/WB pipeline register; stall freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_drnum    <= '0;
      wb_reg_we   <= 1'b0;
      wb_reg_data <= '0;
    end else if (!wb_stall) begin
      wb_valid    <= mem_valid;
      wb_drnum    <= mem_drnum;
      wb_reg_we   <= mem_we_eff;
      wb_reg_data <= mem_reg_data;
    end
  end

  // Register file; entry 0 is never written because wb_reg_we excludes index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_commit && wb_reg_we) begin
      regs[wb_drnum] <= wb_reg_data;
    end
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_instret <= '0;
    end else if (wb_commit) begin
      wb_instret <= wb_instret + 32'd1;
    end
  end

  // Read port A with WB bypass (bypass holds through stalls).
  always_comb begin
    rs1_data = regs[rs1num];
    if (rs1num == '0) begin
      rs1_data = '0;
    end else if (wb_reg_we && (wb_drnum == rs1num)) begin
      rs1_data = wb_reg_data;
    end
  end

  // Read port B, identical structure.
  always_comb begin
    rs2_data = regs[rs2num];
    if (rs2num == '0) begin
      rs2_data = '0;
    end else if (wb_reg_we && (wb_drnum == rs2num)) begin
      rs2_data = wb_reg_data;
    end
  end

endmodule
